// File: rtl/tcm_mem_arb.sv
// tcm_mem_arb: tightly-coupled memory shared by an instruction-fetch port and a
// data port through one single-port RAM (one read or byte-masked write per cycle).
//
// Ports
//   clk_i, rst_i            single clock, synchronous active-high reset
//   mem_i_*                 fetch side: rd/pc request, accept, valid/error/inst response
//   mem_d_*                 data side: addr/wdata/rd/wr/tag + flush/invalidate/writeback
//                           request, accept, ack/error/data/tag response
// Parameters
//   ADDR_W     word-address width, RAM depth 2^ADDR_W words
//   READ_LAT   response latency in cycles (1 or 2)
//   BASE_ADDR  byte base of the TCM window
// Configuration
//   TCM_BOUNDS_CHECK_EN  when defined, accesses outside the window are flagged
//                        with error=1, return zero data and never write the RAM.
//                        When undefined, upper address bits alias and error is 0.
module tcm_mem_arb #(
    parameter int          ADDR_W    = 14,
    parameter int          READ_LAT  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_i_rd_i,
    input  logic [31:0] mem_i_pc_i,
    output logic        mem_i_accept_o,
    output logic        mem_i_valid_o,
    output logic        mem_i_error_o,
    output logic [31:0] mem_i_inst_o,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic [10:0] mem_d_req_tag_i,
    input  logic        mem_d_flush_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [31:0] mem_d_data_rd_o,
    output logic [10:0] mem_d_resp_tag_o
);

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

`ifdef TCM_BOUNDS_CHECK_EN
    // 33-bit bounds so a window ending at 4 GiB does not wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << ADDR_W);

    function automatic logic in_window(input logic [31:0] addr);
        return ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
    endfunction
`endif

    logic [DATA_W-1:0] ram [DEPTH];

    logic              d_req;
    logic              i_req;
    logic              grant_i;
    logic              grant_d;
    logic              lost;
    logic [31:0]       acc_addr;
    logic [ADDR_W-1:0] acc_idx;
    logic              acc_err;
    logic              rd_en;
    logic              wr_en;
    logic              unused_addr;

    // Stage p1: RAM output and response control
    logic              vld_d_p1;
    logic              vld_i_p1;
    logic              err_p1;
    logic [10:0]       tag_p1;
    logic [DATA_W-1:0] rdata_p1;

    // Final response stage (p1 or p2 depending on READ_LAT)
    logic              vld_d_q;
    logic              vld_i_q;
    logic              err_q;
    logic [10:0]       tag_q;
    logic [DATA_W-1:0] rdata_q;

    // Data wins contention unless the fetch was refused last cycle, which makes
    // grants alternate under continuous contention.
    always_comb begin
        d_req   = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i |
                  mem_d_invalidate_i | mem_d_writeback_i;
        i_req   = mem_i_rd_i;
        grant_i = i_req & (~d_req | lost) & ~rst_i;
        grant_d = d_req & ~grant_i & ~rst_i;
        acc_addr = grant_i ? mem_i_pc_i : mem_d_addr_i;
        acc_idx  = acc_addr[ADDR_W+1:2];
`ifdef TCM_BOUNDS_CHECK_EN
        acc_err  = ~in_window(acc_addr);
`else
        acc_err  = 1'b0;
`endif
        // Maintenance-only requests leave the RAM untouched.
        rd_en = grant_i | (grant_d & (mem_d_rd_i | (|mem_d_wr_i)));
        wr_en = grant_d & (|mem_d_wr_i) & ~acc_err;
    end

    // Upper/lower address bits are intentionally ignored in the aliasing build.
    assign unused_addr = ^acc_addr;

    // Read-before-write: a combined rd+wr returns the pre-write word.
    always_ff @(posedge clk_i) begin
        if (rd_en) begin
            rdata_p1 <= ram[acc_idx];
        end
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_d_wr_i[b]) begin
                    ram[acc_idx][8*b +: 8] <= mem_d_data_wr_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_d_p1 <= 1'b0;
            vld_i_p1 <= 1'b0;
            lost     <= 1'b0;
        end else begin
            vld_d_p1 <= grant_d;
            vld_i_p1 <= grant_i;
            lost     <= i_req & ~grant_i;
        end
    end

    always_ff @(posedge clk_i) begin
        err_p1 <= acc_err;
        if (grant_d) begin
            tag_p1 <= mem_d_req_tag_i;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            // Stage p2: extra response delay
            logic              vld_d_p2;
            logic              vld_i_p2;
            logic              err_p2;
            logic [10:0]       tag_p2;
            logic [DATA_W-1:0] rdata_p2;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    vld_d_p2 <= 1'b0;
                    vld_i_p2 <= 1'b0;
                end else begin
                    vld_d_p2 <= vld_d_p1;
                    vld_i_p2 <= vld_i_p1;
                end
            end

            always_ff @(posedge clk_i) begin
                err_p2   <= err_p1;
                tag_p2   <= tag_p1;
                rdata_p2 <= rdata_p1;
            end

            always_comb begin
                vld_d_q = vld_d_p2;
                vld_i_q = vld_i_p2;
                err_q   = err_p2;
                tag_q   = tag_p2;
                rdata_q = rdata_p2;
            end
        end else begin : g_lat1
            always_comb begin
                vld_d_q = vld_d_p1;
                vld_i_q = vld_i_p1;
                err_q   = err_p1;
                tag_q   = tag_p1;
                rdata_q = rdata_p1;
            end
        end
    endgenerate

    // Gating with rst_i suppresses a response already in flight when reset hits.
    always_comb begin
        mem_i_accept_o   = grant_i;
        mem_d_accept_o   = grant_d;
        mem_d_ack_o      = vld_d_q & ~rst_i;
        mem_d_error_o    = vld_d_q & err_q & ~rst_i;
        mem_d_resp_tag_o = (vld_d_q & ~rst_i) ? tag_q : 11'd0;
        mem_d_data_rd_o  = (vld_d_q & ~err_q & ~rst_i) ? rdata_q : '0;
        mem_i_valid_o    = vld_i_q & ~rst_i;
        mem_i_error_o    = vld_i_q & err_q & ~rst_i;
        mem_i_inst_o     = (vld_i_q & ~err_q & ~rst_i) ? rdata_q : '0;
    end

endmodule

// File: tb/tb_tcm_mem_arb.sv
// Directed testbench for tcm_mem_arb: reset, write/read, byte writes,
// fetch, arbitration alternation, maintenance ops, mid-operation reset and
// window handling.
module tb_tcm_mem_arb;

    localparam int LAT = 1;
`ifdef TCM_BOUNDS_CHECK_EN
    localparam logic BOUNDS = 1'b1;
`else
    localparam logic BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_i_rd_i;
    logic [31:0] mem_i_pc_i;
    logic        mem_i_accept_o;
    logic        mem_i_valid_o;
    logic        mem_i_error_o;
    logic [31:0] mem_i_inst_o;
    logic [31:0] mem_d_addr_i;
    logic [31:0] mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_flush_i;
    logic        mem_d_invalidate_i;
    logic        mem_d_writeback_i;
    logic        mem_d_accept_o;
    logic        mem_d_ack_o;
    logic        mem_d_error_o;
    logic [31:0] mem_d_data_rd_o;
    logic [10:0] mem_d_resp_tag_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tcm_mem_arb #(
        .ADDR_W   (14),
        .READ_LAT (LAT),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .mem_i_rd_i         (mem_i_rd_i),
        .mem_i_pc_i         (mem_i_pc_i),
        .mem_i_accept_o     (mem_i_accept_o),
        .mem_i_valid_o      (mem_i_valid_o),
        .mem_i_error_o      (mem_i_error_o),
        .mem_i_inst_o       (mem_i_inst_o),
        .mem_d_addr_i       (mem_d_addr_i),
        .mem_d_data_wr_i    (mem_d_data_wr_i),
        .mem_d_rd_i         (mem_d_rd_i),
        .mem_d_wr_i         (mem_d_wr_i),
        .mem_d_req_tag_i    (mem_d_req_tag_i),
        .mem_d_flush_i      (mem_d_flush_i),
        .mem_d_invalidate_i (mem_d_invalidate_i),
        .mem_d_writeback_i  (mem_d_writeback_i),
        .mem_d_accept_o     (mem_d_accept_o),
        .mem_d_ack_o        (mem_d_ack_o),
        .mem_d_error_o      (mem_d_error_o),
        .mem_d_data_rd_o    (mem_d_data_rd_o),
        .mem_d_resp_tag_o   (mem_d_resp_tag_o)
    );

    task automatic idle_inputs();
        mem_i_rd_i         = 1'b0;
        mem_i_pc_i         = 32'h0;
        mem_d_addr_i       = 32'h0;
        mem_d_data_wr_i    = 32'h0;
        mem_d_rd_i         = 1'b0;
        mem_d_wr_i         = 4'h0;
        mem_d_req_tag_i    = 11'h0;
        mem_d_flush_i      = 1'b0;
        mem_d_invalidate_i = 1'b0;
        mem_d_writeback_i  = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one data request alone, return accept and the response LAT cycles later.
    task automatic d_xact(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [10:0] tag, input logic [2:0] maint,
                          output logic acc, output logic ack, output logic err,
                          output logic [31:0] rdata, output logic [10:0] rtag);
        next_cycle();
        idle_inputs();
        mem_d_rd_i         = rd;
        mem_d_wr_i         = wr;
        mem_d_addr_i       = addr;
        mem_d_data_wr_i    = wdata;
        mem_d_req_tag_i    = tag;
        mem_d_flush_i      = maint[0];
        mem_d_invalidate_i = maint[1];
        mem_d_writeback_i  = maint[2];
        @(negedge clk);
        acc = mem_d_accept_o;
        next_cycle();
        idle_inputs();
        repeat (LAT - 1) next_cycle();
        @(negedge clk);
        ack   = mem_d_ack_o;
        err   = mem_d_error_o;
        rdata = mem_d_data_rd_o;
        rtag  = mem_d_resp_tag_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        mem_i_rd_i = 1'b1;
        mem_d_rd_i = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if ({mem_d_ack_o, mem_i_valid_o, mem_d_error_o, mem_i_error_o, mem_d_resp_tag_o,
             mem_i_accept_o, mem_d_accept_o} !== 17'h0) begin
            failures++;
            $display("FAIL reset_outputs ack=%b valid=%b derr=%b ierr=%b tag=%h iacc=%b dacc=%b exp all 0",
                     mem_d_ack_o, mem_i_valid_o, mem_d_error_o, mem_i_error_o, mem_d_resp_tag_o,
                     mem_i_accept_o, mem_d_accept_o);
        end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_write_read();
        logic exp_ack;
        for (int c = 0; c < LAT + 3; c++) begin
            next_cycle();
            idle_inputs();
            if (c == 0) begin
                mem_d_wr_i      = 4'hF;
                mem_d_addr_i    = 32'h10;
                mem_d_data_wr_i = 32'hDEADBEEF;
                mem_d_req_tag_i = 11'h001;
            end else if (c == 1) begin
                mem_d_rd_i      = 1'b1;
                mem_d_addr_i    = 32'h10;
                mem_d_req_tag_i = 11'h02A;
            end
            @(negedge clk);
            if (c < 2) begin
                checks++;
                if (mem_d_accept_o !== 1'b1) begin
                    failures++;
                    $display("FAIL wr_rd_accept c=%0d got=%b exp=1", c, mem_d_accept_o);
                end
            end
            exp_ack = (c == LAT) || (c == LAT + 1);
            checks++;
            if (mem_d_ack_o !== exp_ack) begin
                failures++;
                $display("FAIL wr_rd_ack c=%0d got=%b exp=%b", c, mem_d_ack_o, exp_ack);
            end
            if (c == LAT) begin
                checks++;
                if (mem_d_resp_tag_o !== 11'h001) begin
                    failures++;
                    $display("FAIL wr_tag got=%h exp=001", mem_d_resp_tag_o);
                end
            end
            if (c == LAT + 1) begin
                checks++;
                if (mem_d_data_rd_o !== 32'hDEADBEEF || mem_d_resp_tag_o !== 11'h02A) begin
                    failures++;
                    $display("FAIL rd_after_wr data=%h tag=%h exp data=deadbeef tag=02a",
                             mem_d_data_rd_o, mem_d_resp_tag_o);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_byte_write();
        logic acc, ack, err;
        logic [31:0] rdata;
        logic [10:0] rtag;
        d_xact(1'b0, 4'hF, 32'h20, 32'h11223344, 11'h003, 3'b000, acc, ack, err, rdata, rtag);
        checks++;
        if ({acc, ack, err} !== 3'b110) begin
            failures++;
            $display("FAIL prefill acc=%b ack=%b err=%b exp 1 1 0", acc, ack, err);
        end
        d_xact(1'b0, 4'b0010, 32'h20, 32'h0000AA00, 11'h004, 3'b000, acc, ack, err, rdata, rtag);
        d_xact(1'b1, 4'h0, 32'h20, 32'h0, 11'h005, 3'b000, acc, ack, err, rdata, rtag);
        checks++;
        if (rdata !== 32'h1122AA44 || rtag !== 11'h005) begin
            failures++;
            $display("FAIL byte_write data=%h tag=%h exp data=1122aa44 tag=005", rdata, rtag);
        end
        // rd together with wr returns the word as it was before the write
        d_xact(1'b1, 4'b0001, 32'h20, 32'h00000055, 11'h006, 3'b000, acc, ack, err, rdata, rtag);
        checks++;
        if (rdata !== 32'h1122AA44) begin
            failures++;
            $display("FAIL rdwr_prewrite data=%h exp=1122aa44", rdata);
        end
        // low address bits ignored
        d_xact(1'b1, 4'h0, 32'h22, 32'h0, 11'h007, 3'b000, acc, ack, err, rdata, rtag);
        checks++;
        if (rdata !== 32'h1122AA55) begin
            failures++;
            $display("FAIL rdwr_postwrite data=%h exp=1122aa55", rdata);
        end
    endtask

    task automatic test_fetch();
        logic acc;
        next_cycle();
        idle_inputs();
        mem_i_rd_i = 1'b1;
        mem_i_pc_i = 32'h10;
        @(negedge clk);
        acc = mem_i_accept_o;
        next_cycle();
        idle_inputs();
        repeat (LAT - 1) next_cycle();
        @(negedge clk);
        checks++;
        if ({acc, mem_i_valid_o, mem_i_error_o} !== 3'b110 || mem_i_inst_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL fetch acc=%b valid=%b err=%b inst=%h exp 1 1 0 deadbeef",
                     acc, mem_i_valid_o, mem_i_error_o, mem_i_inst_o);
        end
    endtask

    task automatic test_alternate();
        int r;
        int acks;
        int valids;
        logic exp_ack, exp_valid;
        acks   = 0;
        valids = 0;
        for (int c = 0; c < 6 + LAT + 2; c++) begin
            next_cycle();
            idle_inputs();
            if (c < 6) begin
                mem_d_rd_i      = 1'b1;
                mem_d_addr_i    = 32'h10;
                mem_d_req_tag_i = 11'(c);
                mem_i_rd_i      = 1'b1;
                mem_i_pc_i      = 32'h20;
            end
            @(negedge clk);
            if (c < 6) begin
                checks++;
                if (mem_d_accept_o !== (c % 2 == 0) || mem_i_accept_o !== (c % 2 == 1)) begin
                    failures++;
                    $display("FAIL alt_grant c=%0d dacc=%b iacc=%b exp dacc=%b", c,
                             mem_d_accept_o, mem_i_accept_o, (c % 2 == 0));
                end
            end
            r = c - LAT;
            exp_ack   = (r >= 0) && (r < 6) && (r % 2 == 0);
            exp_valid = (r >= 0) && (r < 6) && (r % 2 == 1);
            checks++;
            if (mem_d_ack_o !== exp_ack || mem_i_valid_o !== exp_valid) begin
                failures++;
                $display("FAIL alt_resp c=%0d ack=%b valid=%b exp ack=%b valid=%b", c,
                         mem_d_ack_o, mem_i_valid_o, exp_ack, exp_valid);
            end
            if (exp_ack) begin
                checks++;
                if (mem_d_data_rd_o !== 32'hDEADBEEF || mem_d_resp_tag_o !== 11'(r)) begin
                    failures++;
                    $display("FAIL alt_data c=%0d data=%h tag=%h exp deadbeef tag=%h", c,
                             mem_d_data_rd_o, mem_d_resp_tag_o, 11'(r));
                end
            end
            if (exp_valid) begin
                checks++;
                if (mem_i_inst_o !== 32'h1122AA55) begin
                    failures++;
                    $display("FAIL alt_inst c=%0d inst=%h exp=1122aa55", c, mem_i_inst_o);
                end
            end
            if (mem_d_ack_o === 1'b1) acks++;
            if (mem_i_valid_o === 1'b1) valids++;
        end
        checks++;
        if (acks != 3 || valids != 3) begin
            failures++;
            $display("FAIL alt_counts acks=%0d valids=%0d exp 3 3", acks, valids);
        end
        idle_inputs();
    endtask

    task automatic test_maint();
        logic acc, ack, err;
        logic [31:0] rdata;
        logic [10:0] rtag;
        d_xact(1'b0, 4'h0, 32'h10, 32'hFFFFFFFF, 11'h155, 3'b001, acc, ack, err, rdata, rtag);
        checks++;
        if ({acc, ack, err} !== 3'b110 || rtag !== 11'h155) begin
            failures++;
            $display("FAIL flush acc=%b ack=%b err=%b tag=%h exp 1 1 0 155", acc, ack, err, rtag);
        end
        d_xact(1'b0, 4'h0, 32'h10, 32'h0, 11'h2AA, 3'b010, acc, ack, err, rdata, rtag);
        checks++;
        if ({acc, ack} !== 2'b11 || rtag !== 11'h2AA) begin
            failures++;
            $display("FAIL invalidate acc=%b ack=%b tag=%h exp 1 1 2aa", acc, ack, rtag);
        end
        d_xact(1'b1, 4'h0, 32'h10, 32'h0, 11'h011, 3'b000, acc, ack, err, rdata, rtag);
        checks++;
        if (rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL maint_ram_unchanged data=%h exp=deadbeef", rdata);
        end
    endtask

    task automatic test_mid_reset();
        logic exp_ack;
        for (int k = 0; k < LAT + 5; k++) begin
            next_cycle();
            idle_inputs();
            rst = 1'b0;
            if (k <= 2) begin
                mem_d_rd_i      = 1'b1;
                mem_d_addr_i    = 32'h10;
                mem_d_req_tag_i = (k == 2) ? 11'h0C3 : 11'h03C;
                mem_i_rd_i      = 1'b1;
                mem_i_pc_i      = 32'h20;
            end
            if (k == 1) rst = 1'b1;
            @(negedge clk);
            if (k == 0 || k == 2) begin
                checks++;
                if (mem_d_accept_o !== 1'b1 || mem_i_accept_o !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_grant k=%0d dacc=%b iacc=%b exp 1 0", k,
                             mem_d_accept_o, mem_i_accept_o);
                end
            end
            if (k == 1) begin
                checks++;
                if ({mem_d_ack_o, mem_i_valid_o, mem_d_error_o, mem_i_error_o, mem_d_resp_tag_o,
                     mem_i_accept_o, mem_d_accept_o} !== 17'h0) begin
                    failures++;
                    $display("FAIL rst_mid_outputs ack=%b valid=%b tag=%h iacc=%b dacc=%b exp all 0",
                             mem_d_ack_o, mem_i_valid_o, mem_d_resp_tag_o, mem_i_accept_o,
                             mem_d_accept_o);
                end
            end
            if (k >= 2) begin
                exp_ack = (k == 2 + LAT);
                checks++;
                if (mem_d_ack_o !== exp_ack || mem_i_valid_o !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_after k=%0d ack=%b valid=%b exp ack=%b valid=0", k,
                             mem_d_ack_o, mem_i_valid_o, exp_ack);
                end
                if (exp_ack) begin
                    checks++;
                    if (mem_d_resp_tag_o !== 11'h0C3) begin
                        failures++;
                        $display("FAIL rst_after_tag tag=%h exp=0c3", mem_d_resp_tag_o);
                    end
                end
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_window();
        logic acc, ack, err;
        logic [31:0] rdata;
        logic [31:0] exp_word0;
        logic [10:0] rtag;
        exp_word0 = BOUNDS ? 32'h01020304 : 32'hCAFEF00D;
        d_xact(1'b0, 4'hF, 32'h0, 32'h01020304, 11'h040, 3'b000, acc, ack, err, rdata, rtag);
        d_xact(1'b0, 4'hF, 32'h0001_0000, 32'hCAFEF00D, 11'h041, 3'b000, acc, ack, err, rdata, rtag);
        checks++;
        if ({acc, ack} !== 2'b11 || err !== BOUNDS || rtag !== 11'h041) begin
            failures++;
            $display("FAIL window_wr acc=%b ack=%b err=%b tag=%h exp 1 1 %b 041",
                     acc, ack, err, rtag, BOUNDS);
        end
`ifdef TCM_BOUNDS_CHECK_EN
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL window_err_data data=%h exp=0", rdata);
        end
`endif
        d_xact(1'b1, 4'h0, 32'h0, 32'h0, 11'h042, 3'b000, acc, ack, err, rdata, rtag);
        checks++;
        if (rdata !== exp_word0 || err !== 1'b0) begin
            failures++;
            $display("FAIL window_word0 data=%h err=%b exp data=%h err=0", rdata, err, exp_word0);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_byte_write();
        test_fetch();
        test_alternate();
        test_maint();
        test_mid_reset();
        test_window();
        repeat (2) next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
